// File: rtl/vx_ag_tcu_int_sched_if.sv
// Bundle of handshake and data signals between the integer FEDP issue scheduler
// and its environment (command source, operand fetcher, FEDP pipeline, result sink).
//   req_*   : tile command (format, K-step count)
//   op_*    : operand beat request/consume and operand rows/columns
//   fedp_*  : FEDP pipeline control, operands, accumulator in and result back
//   out_*   : final accumulator stream
// Modports: master = environment side, slave = scheduler side.
interface vx_ag_tcu_int_sched_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned NACC = 4,
    parameter int unsigned KW   = 8
);
    localparam int unsigned AW = (NACC > 1) ? $clog2(NACC) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fmt;
    logic [KW-1:0]     req_ksteps;

    logic [AW-1:0]     op_acc;
    logic [KW-1:0]     op_k;
    logic              op_valid;
    logic              op_ready;
    logic [N*32-1:0]   op_a;
    logic [N*32-1:0]   op_b;

    logic              fedp_enable;
    logic [2:0]        fedp_fmt_s;
    logic [N*32-1:0]   fedp_a_row;
    logic [N*32-1:0]   fedp_b_col;
    logic [31:0]       fedp_c_val;
    logic [31:0]       fedp_d_val;

    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_idx;
    logic [31:0]       out_data;

    modport master (
        output req_valid, req_fmt, req_ksteps, op_valid, op_a, op_b, fedp_d_val, out_ready,
        input  req_ready, op_acc, op_k, op_ready, fedp_enable, fedp_fmt_s, fedp_a_row,
               fedp_b_col, fedp_c_val, out_valid, out_idx, out_data
    );

    modport slave (
        input  req_valid, req_fmt, req_ksteps, op_valid, op_a, op_b, fedp_d_val, out_ready,
        output req_ready, op_acc, op_k, op_ready, fedp_enable, fedp_fmt_s, fedp_a_row,
               fedp_b_col, fedp_c_val, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/vx_ag_tcu_int_sched.sv
// Issue scheduler for the integer fused dot-product (FEDP) unit of the AG tensor core.
// Accepts one tile command, issues operand beats in k-major / accumulator round-robin
// order, interleaving NACC accumulators through the fixed-latency FEDP pipeline. A
// per-accumulator pending bit blocks read-after-write hazards; a LATENCY-deep tracking
// shift register marks which FEDP stages carry live work and steers the writeback.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : scheduler side (slave modport) of vx_ag_tcu_int_sched_if
module vx_ag_tcu_int_sched #(
    parameter int unsigned N       = 4,
    parameter int unsigned LATENCY = 5,
    parameter int unsigned NACC    = 4,
    parameter int unsigned KW      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    vx_ag_tcu_int_sched_if.slave        bus
);
    localparam int unsigned AW = (NACC > 1) ? $clog2(NACC) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

    state_e            state_q, state_d;
    logic [2:0]        fmt_q;
    logic [KW-1:0]     ksteps_q;
    logic [KW-1:0]     k_q;
    logic [AW-1:0]     j_q;
    logic [AW-1:0]     out_idx_q;
    logic [NACC-1:0]   pending_q;
    logic [31:0]       acc_q [NACC];
    logic [LATENCY-1:0] trk_vld_q;
    logic [AW-1:0]     trk_idx_q [LATENCY];

    logic              enable;
    logic              accept;
    logic              wb;
    logic [AW-1:0]     wb_idx;
    logic              hit;
    logic              fire;
    logic              last_j;
    logic              last_k;
    logic              out_beat;
    logic              out_last;
    logic [LATENCY-1:0] trk_vld_nxt;

    assign enable   = (state_q == StIssue) || (state_q == StDrain);
    assign accept   = (state_q == StIdle) && bus.req_valid;
    assign wb       = enable && trk_vld_q[LATENCY-1];
    assign wb_idx   = trk_idx_q[LATENCY-1];
    // Writeback to the wanted accumulator this cycle: its result is bypassed, so the
    // pending bit no longer blocks the issue.
    assign hit      = wb && (wb_idx == j_q);
    assign fire     = (state_q == StIssue) && bus.op_valid && (!pending_q[j_q] || hit);
    assign last_j   = (j_q == AW'(NACC - 1));
    assign last_k   = (k_q == ksteps_q - KW'(1));
    assign out_last = (out_idx_q == AW'(NACC - 1));
    assign out_beat = (state_q == StOut) && bus.out_ready;

    // Tracking register contents after this cycle's shift.
    always_comb begin
        trk_vld_nxt    = '0;
        trk_vld_nxt[0] = fire;
        for (int i = 1; i < LATENCY; i++) begin
            trk_vld_nxt[i] = trk_vld_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.req_valid) state_d = StIssue;
            StIssue: if (fire && last_j && last_k) state_d = StDrain;
            // Leave once the last live stage is being written back this cycle.
            StDrain: if (trk_vld_nxt == '0) state_d = StOut;
            StOut:   if (bus.out_ready && out_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_q     <= '0;
            ksteps_q  <= KW'(1);
            k_q       <= '0;
            j_q       <= '0;
            out_idx_q <= '0;
            pending_q <= '0;
            trk_vld_q <= '0;
            for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
            for (int i = 0; i < LATENCY; i++) trk_idx_q[i] <= '0;
        end else begin
            if (enable) begin
                trk_vld_q    <= trk_vld_nxt;
                trk_idx_q[0] <= j_q;
                for (int i = 1; i < LATENCY; i++) trk_idx_q[i] <= trk_idx_q[i-1];
            end
            if (wb) begin
                acc_q[wb_idx]     <= bus.fedp_d_val;
                pending_q[wb_idx] <= 1'b0;
            end
            // Placed after the writeback so a same-cycle bypass re-arms the bit.
            if (fire) begin
                pending_q[j_q] <= 1'b1;
                if (last_j) begin
                    j_q <= '0;
                    k_q <= k_q + KW'(1);
                end else begin
                    j_q <= j_q + AW'(1);
                end
            end
            if (accept) begin
                fmt_q     <= bus.req_fmt;
                ksteps_q  <= (bus.req_ksteps == '0) ? KW'(1) : bus.req_ksteps;
                k_q       <= '0;
                j_q       <= '0;
                pending_q <= '0;
                trk_vld_q <= '0;
                for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
            end
            if (out_beat) begin
                out_idx_q <= out_last ? '0 : out_idx_q + AW'(1);
            end
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.op_acc      = j_q;
    assign bus.op_k        = k_q;
    assign bus.op_ready    = fire;
    assign bus.fedp_enable = enable;
    assign bus.fedp_fmt_s  = fmt_q;
    assign bus.fedp_a_row  = fire ? bus.op_a : {N*32{1'b0}};
    assign bus.fedp_b_col  = fire ? bus.op_b : {N*32{1'b0}};
    assign bus.fedp_c_val  = hit ? bus.fedp_d_val : acc_q[j_q];
    assign bus.out_valid   = (state_q == StOut);
    assign bus.out_idx     = out_idx_q;
    assign bus.out_data    = (state_q == StOut) ? acc_q[out_idx_q] : 32'd0;
endmodule

// File: tb/tb_vx_ag_tcu_int_sched.sv
// Self-checking bench for vx_ag_tcu_int_sched. Contains a behavioural FEDP pipeline
// (environment) and a reference model that computes each accumulator as the sum over
// K of lane dot products, plus issue order, hazard spacing and cycle-count rules.
module tb_vx_ag_tcu_int_sched;
    localparam int unsigned N       = 4;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned NACC    = 4;
    localparam int unsigned KW      = 8;
    localparam int unsigned MAXK    = 8;
    localparam int unsigned DW      = N * 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vx_ag_tcu_int_sched_if #(.N(N), .NACC(NACC), .KW(KW)) bus ();

    vx_ag_tcu_int_sched #(.N(N), .LATENCY(LATENCY), .NACC(NACC), .KW(KW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] opa [MAXK][NACC];
    logic [DW-1:0] opb [MAXK][NACC];
    logic [31:0]   exp_acc [NACC];
    logic [31:0]   part [NACC];
    int            last_fire [NACC];
    logic [31:0]   pipe [LATENCY];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Integer dot product of one beat: N lanes, 4 bytes or 8 nibbles per lane.
    function automatic logic [31:0] dot(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [2:0] fmt);
        logic [31:0] s;
        s = 32'd0;
        for (int l = 0; l < N; l++) begin
            for (int e = 0; e < 8; e++) begin
                logic [7:0] ba, bb;
                logic [3:0] na, nb;
                int pa, pb;
                pa = 0;
                pb = 0;
                ba = a[l*32 + (e%4)*8 +: 8];
                bb = b[l*32 + (e%4)*8 +: 8];
                na = a[l*32 + e*4 +: 4];
                nb = b[l*32 + e*4 +: 4];
                case (fmt)
                    3'd1: if (e < 4) begin pa = int'($signed(ba)); pb = int'($signed(bb)); end
                    3'd2: if (e < 4) begin pa = int'(ba); pb = int'(bb); end
                    3'd3: begin pa = int'($signed(na)); pb = int'($signed(nb)); end
                    3'd4: begin pa = int'(na); pb = int'(nb); end
                    default: ;
                endcase
                s = s + 32'(pa * pb);
            end
        end
        return s;
    endfunction

    // pat 0: 0x01../0x02.., pat 1: 0x80.. both, pat 2: random.
    // vmode 0: op_valid always, 1: random, 2: 3-cycle starvation mid-issue.
    // bmode 0: out_ready always, 1: random, 2: held low for the first 4 OUT cycles.
    task automatic run_cmd(input int pat, input logic [2:0] fmt, input int kreq,
                           input int vmode, input int bmode, input bit abort);
        int K, c0, nfire, ek, ej, oidx, firstfire, lastf, firstout, starve, bp, issue;
        bit done, en;
        logic [31:0] x;
        K = (kreq == 0) ? 1 : kreq;
        for (int k = 0; k < int'(MAXK); k++) begin
            for (int j = 0; j < int'(NACC); j++) begin
                for (int w = 0; w < int'(N); w++) begin
                    case (pat)
                        0: begin opa[k][j][w*32 +: 32] = 32'h01010101;
                                 opb[k][j][w*32 +: 32] = 32'h02020202; end
                        1: begin opa[k][j][w*32 +: 32] = 32'h80808080;
                                 opb[k][j][w*32 +: 32] = 32'h80808080; end
                        default: begin opa[k][j][w*32 +: 32] = $urandom;
                                       opb[k][j][w*32 +: 32] = $urandom; end
                    endcase
                end
            end
        end
        for (int j = 0; j < int'(NACC); j++) begin
            if (pat == 0 && fmt == 3'd1) exp_acc[j] = 32'(32 * K);
            else if (pat == 1 && fmt == 3'd1) exp_acc[j] = 32'(262144 * K);
            else begin
                exp_acc[j] = 32'd0;
                for (int k = 0; k < K; k++) exp_acc[j] = exp_acc[j] + dot(opa[k][j], opb[k][j], fmt);
            end
            part[j] = 32'd0;
            last_fire[j] = -1;
        end
        bus.req_valid  = 1'b1;
        bus.req_fmt    = fmt;
        bus.req_ksteps = KW'(kreq);
        bus.op_valid   = 1'b0;
        bus.out_ready  = (bmode == 0);
        c0 = -1; nfire = 0; ek = 0; ej = 0; oidx = 0;
        firstfire = -1; lastf = -1; firstout = -1; starve = 0; bp = 0; done = 0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            en = bus.fedp_enable;
            x  = dot(bus.fedp_a_row, bus.fedp_b_col, bus.fedp_fmt_s) + bus.fedp_c_val;
            if (c0 < 0 && bus.req_valid && bus.req_ready) c0 = cyc;
            if (bus.op_ready) begin
                check_eq("op_k", 32'(bus.op_k), 32'(ek));
                check_eq("op_acc", 32'(bus.op_acc), 32'(ej));
                check_eq("a_row_fwd", 32'(bus.fedp_a_row == opa[ek][ej]), 32'd1);
                check_eq("b_col_fwd", 32'(bus.fedp_b_col == opb[ek][ej]), 32'd1);
                check_eq("c_val", bus.fedp_c_val, part[ej]);
                if (last_fire[ej] >= 0)
                    check_eq("dep_spacing", 32'(cyc - last_fire[ej] >= int'(LATENCY)), 32'd1);
                part[ej] = part[ej] + dot(opa[ek][ej], opb[ek][ej], fmt);
                last_fire[ej] = cyc;
                nfire++;
                lastf = cyc;
                if (firstfire < 0) firstfire = cyc;
                ej++;
                if (ej == int'(NACC)) begin ej = 0; ek++; end
            end else if (en) begin
                check_eq("bubble_zero", 32'(bus.fedp_a_row == '0 && bus.fedp_b_col == '0), 32'd1);
            end
            if (bus.out_valid) begin
                if (firstout < 0) firstout = cyc;
                check_eq("out_fedp_en", 32'(bus.fedp_enable), 32'd0);
                check_eq("out_req_ready", 32'(bus.req_ready), 32'd0);
                check_eq("out_idx", 32'(bus.out_idx), 32'(oidx));
                check_eq("out_data", bus.out_data, exp_acc[oidx]);
                if (bus.out_ready) begin
                    oidx++;
                    if (oidx == int'(NACC)) done = 1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (en) begin
                for (int i = int'(LATENCY) - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = x;
            end
            bus.fedp_d_val = pipe[LATENCY-1];
            if (c0 >= 0) bus.req_valid = 1'b0;
            case (vmode)
                0: bus.op_valid = 1'b1;
                1: bus.op_valid = ($urandom % 4) != 0;
                default: begin
                    bus.op_valid = !(nfire == 5 && starve < 3);
                    if (!bus.op_valid) starve++;
                end
            endcase
            if (int'(bus.op_k) < int'(MAXK)) begin
                bus.op_a = opa[bus.op_k][bus.op_acc];
                bus.op_b = opb[bus.op_k][bus.op_acc];
            end else begin
                bus.op_a = '0;
                bus.op_b = '0;
            end
            case (bmode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom % 3) != 0;
                default: begin
                    bus.out_ready = !(bus.out_valid && bp < 4);
                    if (!bus.out_ready) bp++;
                end
            endcase
            if (abort && !done && nfire == K * int'(NACC) && cyc == lastf + 3) begin
                reset_n = 1'b0;
                #1;
                check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
                check_eq("rst_fedp_en", 32'(bus.fedp_enable), 32'd0);
                check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
                done = 1;
            end
        end
        if (!done) check_eq("timeout", 32'd0, 32'd1);
        if (!abort) begin
            check_eq("fire_count", 32'(nfire), 32'(K * int'(NACC)));
            if (vmode == 0) begin
                issue = (NACC >= LATENCY) ? K * int'(NACC) : (K - 1) * int'(LATENCY) + int'(NACC);
                check_eq("first_fire", 32'(firstfire - c0), 32'd1);
                check_eq("issue_cycles", 32'(lastf - c0), 32'(issue));
                check_eq("out_entry", 32'(firstout - lastf), 32'(LATENCY + 1));
            end
        end
        bus.op_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_fmt    = 3'd0;
        bus.req_ksteps = '0;
        bus.op_valid   = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.fedp_d_val = 32'd0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < int'(LATENCY); i++) pipe[i] = 32'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_op_ready", 32'(bus.op_ready), 32'd0);
        check_eq("rst_op_acc", 32'(bus.op_acc), 32'd0);
        check_eq("rst_op_k", 32'(bus.op_k), 32'd0);
        check_eq("rst_fedp_en", 32'(bus.fedp_enable), 32'd0);
        check_eq("rst_fmt_s", 32'(bus.fedp_fmt_s), 32'd0);
        check_eq("rst_a_row", 32'(bus.fedp_a_row == '0), 32'd1);
        check_eq("rst_b_col", 32'(bus.fedp_b_col == '0), 32'd1);
        check_eq("rst_c_val", bus.fedp_c_val, 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check_eq("rst_out_data", bus.out_data, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(0, 3'd1, 1, 0, 0, 0);   // baseline
        run_cmd(0, 3'd1, 3, 0, 0, 0);   // multi-step with bypass
        run_cmd(1, 3'd1, 1, 0, 0, 0);   // signed 0x80 products
        run_cmd(1, 3'd1, 4, 0, 0, 0);
        run_cmd(0, 3'd1, 3, 2, 0, 0);   // operand starvation
        run_cmd(2, 3'd2, 2, 0, 2, 0);   // output backpressure
        run_cmd(0, 3'd1, 3, 0, 0, 1);   // reset during drain
        run_cmd(0, 3'd1, 1, 0, 0, 0);   // clean command after reset
        run_cmd(2, 3'd3, 0, 0, 0, 0);   // ksteps 0 behaves as 1
        for (int r = 0; r < 12; r++) begin
            run_cmd(2, 3'(1 + $urandom % 4), 1 + int'($urandom % 6), 1, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
